adc366x_cond: RTL and testbench

Conditioning stage directly downstream of the ADC366x LVDS receiver, in the adc_clk_i domain. Consumes the receiver's 32-bit two-channel word and valid strobe. Per channel it applies:
- format conversion to two's complement;
- offset correction, then gain correction, with rounding and saturation.

It also tracks valid-stream continuity (lock, error count) and raises sticky saturation flags, so downstream acquisition logic sees calibrated, qualified samples.

---
 rtl/adc366x_cond.sv | 173 +++++++++++++++++
 tb/tb_adc366x_cond.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adc366x_cond.sv
// ADC366x conditioning: format, offset, gain, lock tracking.
// Ports: adc_* receiver in, cfg_* static config, dat/dv/lock/sat/err out.
module adc366x_cond #(
  parameter int LOCK_CNT = 16,
  parameter int GSH      = 14
) (
  input  logic        adc_clk_i,
  input  logic        adc_rst_i,
  input  logic [31:0] adc_dat_i,
  input  logic        adc_dv_i,
  input  logic        cfg_fmt_i,
  input  logic [15:0] cfg_ofs_a_i,
  input  logic [15:0] cfg_ofs_b_i,
  input  logic [15:0] cfg_gain_a_i,
  input  logic [15:0] cfg_gain_b_i,
  input  logic        cfg_clr_i,
  output logic [15:0] dat_a_o,
  output logic [15:0] dat_b_o,
  output logic        dv_o,
  output logic        lock_o,
  output logic [15:0] dv_err_cnt_o,
  output logic        sat_a_o,
  output logic        sat_b_o
);

  localparam logic [0:0]  ST_UNLOCK = 1'b0;
  localparam logic [0:0]  ST_LOCKED = 1'b1;
  localparam logic [15:0] LC_M1     = 16'(LOCK_CNT - 1);
  localparam logic [33:0] RND       = 34'(1) << (GSH - 1);

  logic [0:0]  r_state;
  logic [15:0] r_run;
  logic [15:0] r_err;
  logic        w_q;

  logic        r_q1, r_q2, r_q3, r_q4;
  logic [15:0] r_x   [2];
  logic [15:0] r_y   [2];
  logic        r_sf1 [2];
  logic [32:0] r_p   [2];
  logic        r_sf2 [2];
  logic [15:0] r_out [2];
  logic        r_sf3 [2];
  logic        r_sat [2];

  logic [15:0]        w_in   [2];
  logic [15:0]        w_ofs  [2];
  logic [15:0]        w_gain [2];
  logic [16:0]        w_sum  [2];
  logic [15:0]        w_y    [2];
  logic               w_c2   [2];
  logic signed [32:0] w_prod [2];
  logic signed [33:0] w_rnd  [2];
  logic signed [33:0] w_sh   [2];
  logic [15:0]        w_r    [2];
  logic               w_c4   [2];

  assign w_in[0]   = adc_dat_i[15:0];
  assign w_in[1]   = adc_dat_i[31:16];
  assign w_ofs[0]  = cfg_ofs_a_i;
  assign w_ofs[1]  = cfg_ofs_b_i;
  assign w_gain[0] = cfg_gain_a_i;
  assign w_gain[1] = cfg_gain_b_i;

  // Qualification uses the lock state held before this edge.
  assign w_q = adc_dv_i & r_state[0];

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      r_state <= ST_UNLOCK;
      r_run   <= '0;
    end else begin
      unique case (r_state)
        ST_UNLOCK: begin
          if (!adc_dv_i) begin
            r_run <= '0;
          end else if (r_run == LC_M1) begin
            r_state <= ST_LOCKED;
            r_run   <= '0;
          end else begin
            r_run <= r_run + 16'd1;
          end
        end
        default: begin
          r_run <= '0;
          if (!adc_dv_i) r_state <= ST_UNLOCK;
        end
      endcase
    end
  end

  // Clear has priority over a lock-loss increment.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      r_err <= '0;
    end else if (cfg_clr_i) begin
      r_err <= '0;
    end else if (r_state == ST_LOCKED && !adc_dv_i && r_err != 16'hFFFF) begin
      r_err <= r_err + 16'd1;
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_sum[c] = {r_x[c][15], r_x[c]} + {w_ofs[c][15], w_ofs[c]};
      w_c2[c]  = w_sum[c][16] != w_sum[c][15];
      w_y[c]   = w_c2[c] ? (w_sum[c][16] ? 16'h8000 : 16'h7FFF)
                         : w_sum[c][15:0];
      w_prod[c] = $signed(r_y[c]) * $signed({1'b0, w_gain[c]});
      w_rnd[c]  = $signed({r_p[c][32], r_p[c]} + RND);
      w_sh[c]   = w_rnd[c] >>> GSH;
      // In range only when bits 33..15 are a pure sign extension.
      w_c4[c]  = !((&w_sh[c][33:15]) || !(|w_sh[c][33:15]));
      w_r[c]   = w_c4[c] ? (w_sh[c][33] ? 16'h8000 : 16'h7FFF)
                         : w_sh[c][15:0];
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
      r_q3 <= 1'b0;
      r_q4 <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_x[c]   <= '0;
        r_y[c]   <= '0;
        r_sf1[c] <= 1'b0;
        r_p[c]   <= '0;
        r_sf2[c] <= 1'b0;
        r_out[c] <= '0;
        r_sf3[c] <= 1'b0;
      end
    end else begin
      r_q1 <= w_q;
      r_q2 <= r_q1;
      r_q3 <= r_q2;
      r_q4 <= r_q3;
      for (int c = 0; c < 2; c++) begin
        // Offset binary becomes two's complement by flipping the MSB.
        r_x[c]   <= w_q ? {w_in[c][15] ^ ~cfg_fmt_i, w_in[c][14:0]}
                        : 16'h0000;
        r_y[c]   <= w_y[c];
        r_sf1[c] <= w_c2[c];
        r_p[c]   <= w_prod[c];
        r_sf2[c] <= r_sf1[c];
        r_out[c] <= w_r[c];
        r_sf3[c] <= r_sf2[c] | w_c4[c];
      end
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      r_sat[0] <= 1'b0;
      r_sat[1] <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (cfg_clr_i)                r_sat[c] <= 1'b0;
        else if (r_q4 && r_sf3[c])    r_sat[c] <= 1'b1;
      end
    end
  end

  assign dat_a_o      = r_out[0];
  assign dat_b_o      = r_out[1];
  assign dv_o         = r_q4;
  assign lock_o       = r_state[0];
  assign dv_err_cnt_o = r_err;
  assign sat_a_o      = r_sat[0];
  assign sat_b_o      = r_sat[1];

endmodule

// File: tb/tb_adc366x_cond.sv
// Bench for adc366x_cond: directed vectors, queue scoreboard.
// Driver pushes expected samples, monitor pops on dv_o.
module tb_adc366x_cond;

  typedef struct {
    logic        ck;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dat = '0;
  logic        dv  = 1'b0;
  logic        fmt = 1'b0;
  logic [15:0] ofs_a = '0, ofs_b = '0;
  logic [15:0] gain_a = 16'h4000, gain_b = 16'h4000;
  logic        clr = 1'b0;
  logic [15:0] dat_a, dat_b, err_cnt;
  logic        dv_o, lock_o, sat_a, sat_b;

  int   tests = 0;
  int   errs  = 0;
  exp_t sb[$];
  exp_t e_m;
  logic m_lock = 1'b0;
  int   m_run  = 0;

  adc366x_cond #(.LOCK_CNT(16), .GSH(14)) dut (
    .adc_clk_i(clk), .adc_rst_i(rst),
    .adc_dat_i(dat), .adc_dv_i(dv),
    .cfg_fmt_i(fmt),
    .cfg_ofs_a_i(ofs_a), .cfg_ofs_b_i(ofs_b),
    .cfg_gain_a_i(gain_a), .cfg_gain_b_i(gain_b),
    .cfg_clr_i(clr),
    .dat_a_o(dat_a), .dat_b_o(dat_b), .dv_o(dv_o),
    .lock_o(lock_o), .dv_err_cnt_o(err_cnt),
    .sat_a_o(sat_a), .sat_b_o(sat_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && dv_o) begin
      if (sb.size() == 0) begin
        tests++;
        errs++;
        $display("FAIL unexpected_dv: got dv_o=1 expected no sample");
      end else begin
        e_m = sb.pop_front();
        if (e_m.ck) begin
          chk("dat_a", {16'h0, dat_a}, {16'h0, e_m.a});
          chk("dat_b", {16'h0, dat_b}, {16'h0, e_m.b});
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] a, b,
                     input logic [15:0] ea, eb, input logic ck);
    exp_t e;
    @(negedge clk);
    dv  = v;
    dat = {b, a};
    if (v && m_lock) begin
      e.ck = ck; e.a = ea; e.b = eb;
      sb.push_back(e);
    end
    if (!m_lock) begin
      if (!v)              m_run = 0;
      else if (m_run == 15) begin m_lock = 1'b1; m_run = 0; end
      else                 m_run++;
    end else if (!v) begin
      m_lock = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  // Neutral samples: x = 0 regardless of format, so never clip.
  task automatic fill(input int n);
    logic [15:0] z;
    z = fmt ? 16'h0000 : 16'h8000;
    for (int i = 0; i < n; i++) cyc(1'b1, z, z, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_dat_a", {16'h0, dat_a}, 32'h0);
    chk("rst_dat_b", {16'h0, dat_b}, 32'h0);
    chk("rst_dv", {31'h0, dv_o}, 32'h0);
    chk("rst_lock", {31'h0, lock_o}, 32'h0);
    chk("rst_err", {16'h0, err_cnt}, 32'h0);
    chk("rst_sat", {30'h0, sat_a, sat_b}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Lock and latency
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 16'h8000, 16'h8000, 16'h0, 16'h0, 1'b1);
      if (i == 15) chk("lock_pre", {31'h0, lock_o}, 32'h0);
      if (i == 16) chk("lock_set", {31'h0, lock_o}, 32'h1);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 16'h8000, 16'h8000, 16'h0, 16'h0, 1'b1);
      chk("latency_dv", {31'h0, dv_o}, (i == 4) ? 32'h1 : 32'h0);
    end
    fill(3);

    // Gain
    fmt = 1'b1; gain_a = 16'h8000;
    cyc(1'b1, 16'h3000, 16'h0100, 16'h6000, 16'h0100, 1'b1);
    fill(4);
    chk("sat_a_clear", {31'h0, sat_a}, 32'h0);
    cyc(1'b1, 16'h5000, 16'h0200, 16'h7FFF, 16'h0200, 1'b1);
    fill(4);
    chk("sat_a_set", {31'h0, sat_a}, 32'h1);
    chk("sat_b_idle", {31'h0, sat_b}, 32'h0);

    // Offset clip
    gain_a = 16'h4000; ofs_b = 16'hFFF0;
    cyc(1'b1, 16'h0000, 16'h8005, 16'h0000, 16'h8000, 1'b1);
    fill(4);
    chk("sat_b_set", {31'h0, sat_b}, 32'h1);
    chk("sat_a_sticky", {31'h0, sat_a}, 32'h1);
    fmt = 1'b0; ofs_b = 16'h0010;
    cyc(1'b1, 16'h8000, 16'h0010, 16'h0000, 16'h8020, 1'b1);
    fill(3);

    // Rounding
    fmt = 1'b1; ofs_b = 16'h0; gain_a = 16'h2000; gain_b = 16'h2000;
    cyc(1'b1, 16'h0003, 16'hFFFD, 16'h0002, 16'hFFFF, 1'b1);
    cyc(1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b1);
    cyc(1'b1, 16'hFFFD, 16'h0003, 16'hFFFF, 16'h0002, 1'b1);
    fill(3);

    // Zero and maximum gain
    gain_a = 16'h0000; gain_b = 16'hFFFF;
    cyc(1'b1, 16'h7FFF, 16'h9000, 16'h0000, 16'h8000, 1'b1);
    cyc(1'b1, 16'h8000, 16'h0001, 16'h0000, 16'h0004, 1'b1);
    fill(3);

    // Lock loss and relock
    gain_a = 16'h4000; gain_b = 16'h4000;
    fill(3);
    chk("err_zero", {16'h0, err_cnt}, 32'h0);
    cyc(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("lock_lost", {31'h0, lock_o}, 32'h0);
    chk("err_one", {16'h0, err_cnt}, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 16'(i), 16'(-i), 16'(i), 16'(-i), 1'b1);
      if (i == 2)  chk("drain_dv", {31'h0, dv_o}, 32'h1);
      if (i == 3)  chk("drop_dv", {31'h0, dv_o}, 32'h0);
      if (i == 15) chk("relock_pre", {31'h0, lock_o}, 32'h0);
      if (i == 16) chk("relock", {31'h0, lock_o}, 32'h1);
      if (i == 19) chk("relock_dv_pre", {31'h0, dv_o}, 32'h0);
      if (i == 20) chk("relock_dv", {31'h0, dv_o}, 32'h1);
    end
    fill(3);

    // Clear beats a simultaneous saturation set
    gain_a = 16'hFFFF;
    cyc(1'b1, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
    fill(2);
    clr = 1'b1;
    fill(2);
    clr = 1'b0;
    chk("clr_sat", {30'h0, sat_a, sat_b}, 32'h0);
    chk("clr_err", {16'h0, err_cnt}, 32'h0);
    fill(1);
    chk("clr_sat_hold", {31'h0, sat_a}, 32'h0);

    // Asynchronous reset mid-stream
    cyc(1'b1, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
    fill(3);
    chk("pre_rst_dat_a", {16'h0, dat_a}, 32'h7FFF);
    #1 rst = 1'b1;
    #1;
    chk("arst_dat_a", {16'h0, dat_a}, 32'h0);
    chk("arst_dat_b", {16'h0, dat_b}, 32'h0);
    chk("arst_dv", {31'h0, dv_o}, 32'h0);
    chk("arst_lock", {31'h0, lock_o}, 32'h0);
    chk("arst_err", {16'h0, err_cnt}, 32'h0);
    chk("arst_sat", {30'h0, sat_a, sat_b}, 32'h0);
    sb.delete();
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
